// File: rtl/debounce_pkg.sv
// rtl/debounce_pkg.sv - shared constants and helpers for the multi-channel debouncer
package debounce_pkg;

   localparam int cDEBOUNCE_MAX_CH = 32;

   function automatic int ctr_width(input longint unsigned maxClks);
      return $clog2(maxClks + 64'd1);
   endfunction

endpackage

// File: rtl/debounce_chan.sv
// rtl/debounce_chan.sv - single debounce channel with separate rise/fall stability thresholds
module debounce_chan
   import debounce_pkg::*;
#(
   parameter int unsigned pCLKS_RISE = 32'd1_000_000,
   parameter int unsigned pCLKS_FALL = 32'd1_000_000,
   parameter logic        pINIT      = 1'b0
) (
   input  logic iCLK,
   input  logic iRESET,
   input  logic iSIG,
   output logic oSIG,
   output logic oRISE,
   output logic oFALL,
   output logic oFLIP
);

   localparam int unsigned cMAX = (pCLKS_RISE > pCLKS_FALL) ? pCLKS_RISE : pCLKS_FALL;
   localparam int          cW   = ctr_width(cMAX);

   if (pCLKS_RISE == 0 || pCLKS_FALL == 0) begin : gBadClks
      $fatal(1, "debounce_chan: pCLKS_RISE and pCLKS_FALL must be >= 1");
   end

   logic [cW-1:0] count;
   logic [cW-1:0] limit;

   assign limit = oSIG ? cW'(pCLKS_FALL - 1) : cW'(pCLKS_RISE - 1);

   // Combinational flip indicator lets the top register oCHANGED in step with oRISE/oFALL.
   assign oFLIP = (iSIG != oSIG) && (count == limit);

   always_ff @(posedge iCLK) begin
      if (iRESET) begin
         oSIG  <= pINIT;
         count <= '0;
         oRISE <= 1'b0;
         oFALL <= 1'b0;
      end else begin
         oRISE <= 1'b0;
         oFALL <= 1'b0;
         if (iSIG == oSIG) begin
            count <= '0;
         end else if (count == limit) begin
            oSIG  <= iSIG;
            count <= '0;
            oRISE <= iSIG;
            oFALL <= ~iSIG;
         end else begin
            count <= count + cW'(1);
         end
      end
   end

endmodule

// File: rtl/debounce_multi.sv
// rtl/debounce_multi.sv - N-channel debouncer with edge pulses; DEBOUNCE_MULTI_SYNC_EN adds a 2-flop input synchroniser
module debounce_multi
   import debounce_pkg::*;
#(
   parameter int                   pCHANNELS  = 8,
   parameter int unsigned          pCLKS_RISE = 32'd1_000_000,
   parameter int unsigned          pCLKS_FALL = 32'd1_000_000,
   parameter logic [pCHANNELS-1:0] pINIT      = {pCHANNELS{1'b0}}
) (
   input  logic                 iCLK,
   input  logic                 iRESET,
   input  logic [pCHANNELS-1:0] iSIG,
   output logic [pCHANNELS-1:0] oSIG,
   output logic [pCHANNELS-1:0] oRISE,
   output logic [pCHANNELS-1:0] oFALL,
   output logic                 oCHANGED
);

   if (pCHANNELS < 1 || pCHANNELS > cDEBOUNCE_MAX_CH) begin : gBadCh
      $fatal(1, "debounce_multi: pCHANNELS must be in 1..32");
   end

   logic [pCHANNELS-1:0] sampled;
   logic [pCHANNELS-1:0] flip;

`ifdef DEBOUNCE_MULTI_SYNC_EN
   logic [pCHANNELS-1:0] syncA;
   logic [pCHANNELS-1:0] syncB;

   always_ff @(posedge iCLK) begin
      if (iRESET) begin
         syncA <= pINIT;
         syncB <= pINIT;
      end else begin
         syncA <= iSIG;
         syncB <= syncA;
      end
   end

   assign sampled = syncB;
`else
   assign sampled = iSIG;
`endif

   for (genvar i = 0; i < pCHANNELS; i++) begin : gChan
      debounce_chan #(
         .pCLKS_RISE (pCLKS_RISE),
         .pCLKS_FALL (pCLKS_FALL),
         .pINIT      (pINIT[i])
      ) uChan (
         .iCLK   (iCLK),
         .iRESET (iRESET),
         .iSIG   (sampled[i]),
         .oSIG   (oSIG[i]),
         .oRISE  (oRISE[i]),
         .oFALL  (oFALL[i]),
         .oFLIP  (flip[i])
      );
   end

   always_ff @(posedge iCLK) begin
      if (iRESET) begin
         oCHANGED <= 1'b0;
      end else begin
         oCHANGED <= |flip;
      end
   end

endmodule

// File: tb/tb_debounce_multi.sv
// tb/tb_debounce_multi.sv - scoreboard bench for debounce_multi (4 channels, rise 5, fall 3, init 4'b0010)
module tb_debounce_multi;

   localparam logic [3:0] cINIT = 4'b0010;
`ifdef DEBOUNCE_MULTI_SYNC_EN
   localparam int cS = 2;
`else
   localparam int cS = 0;
`endif

   typedef struct packed {
      logic [3:0] sig;
      logic [3:0] rise;
      logic [3:0] fall;
      logic       chg;
   } exp_t;

   logic       iCLK = 1'b0;
   logic       iRESET = 1'b1;
   logic [3:0] iSIG = cINIT;
   logic [3:0] oSIG, oRISE, oFALL;
   logic       oCHANGED;

   exp_t       expQ[$];
   logic [3:0] expSig = cINIT;
   int         vectors = 0;
   int         miscompares = 0;
   logic       stimDone = 1'b0;

   debounce_multi #(
      .pCHANNELS  (4),
      .pCLKS_RISE (5),
      .pCLKS_FALL (3),
      .pINIT      (cINIT)
   ) dut (
      .iCLK     (iCLK),
      .iRESET   (iRESET),
      .iSIG     (iSIG),
      .oSIG     (oSIG),
      .oRISE    (oRISE),
      .oFALL    (oFALL),
      .oCHANGED (oCHANGED)
   );

   always #5 iCLK = ~iCLK;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: bench did not finish, vectors=%0d", vectors);
      $fatal(1, "watchdog");
   end

   // Monitor: one expectation per clock edge, checked just after the edge.
   initial begin
      exp_t e;
      forever begin
         @(posedge iCLK);
         #1;
         if (expQ.size() > 0) begin
            e = expQ.pop_front();
            vectors++;
            if (oSIG !== e.sig || oRISE !== e.rise || oFALL !== e.fall || oCHANGED !== e.chg) begin
               miscompares++;
               $display("FAIL vec%0d: got sig=%b rise=%b fall=%b chg=%b, want sig=%b rise=%b fall=%b chg=%b",
                        vectors, oSIG, oRISE, oFALL, oCHANGED, e.sig, e.rise, e.fall, e.chg);
            end
         end
      end
   end

   task automatic doReset(input logic [3:0] sig, input int n);
      for (int k = 0; k < n; k++) begin
         @(negedge iCLK);
         iRESET = 1'b1;
         iSIG   = sig;
         expSig = cINIT;
         expQ.push_back('{sig: cINIT, rise: 4'b0, fall: 4'b0, chg: 1'b0});
      end
      @(negedge iCLK);
      iRESET = 1'b0;
   endtask

   // Hold sig for n edges; e1/e2 are the hand-computed edge numbers (1-based, 0 = none)
   // at which the given rise/fall masks are expected.
   task automatic run(input logic [3:0] sig, input int n,
                      input int e1, input logic [3:0] r1, input logic [3:0] f1,
                      input int e2, input logic [3:0] r2, input logic [3:0] f2);
      logic [3:0] r, f;
      for (int k = 1; k <= n; k++) begin
         if (k > 1) @(negedge iCLK);
         iSIG = sig;
         r = ((k == e1) ? r1 : 4'b0) | ((k == e2) ? r2 : 4'b0);
         f = ((k == e1) ? f1 : 4'b0) | ((k == e2) ? f2 : 4'b0);
         expSig = (expSig | r) & ~f;
         expQ.push_back('{sig: expSig, rise: r, fall: f, chg: |(r | f)});
      end
      @(negedge iCLK);
   endtask

   initial begin
      // Reset state and quiet period after release.
      doReset(4'b0010, 3);
      run(4'b0010, 20, 0, 4'b0, 4'b0, 0, 4'b0, 4'b0);

      // Single rise on channel 0, then fall back.
      run(4'b0011, 5 + cS + 3, 5 + cS, 4'b0001, 4'b0, 0, 4'b0, 4'b0);
      run(4'b0010, 3 + cS + 2, 3 + cS, 4'b0, 4'b0001, 0, 4'b0, 4'b0);

      // Glitch restarts the count: high 4, low 1, high 4 never flips.
      run(4'b0011, 4, 0, 4'b0, 4'b0, 0, 4'b0, 4'b0);
      run(4'b0010, 1, 0, 4'b0, 4'b0, 0, 4'b0, 4'b0);
      run(4'b0011, 4, 0, 4'b0, 4'b0, 0, 4'b0, 4'b0);
      run(4'b0010, 6, 0, 4'b0, 4'b0, 0, 4'b0, 4'b0);

      // Simultaneous step: ch1 falls after 3, ch2 rises after 5, separate oCHANGED pulses.
      run(4'b0100, 5 + cS + 3, 3 + cS, 4'b0, 4'b0010, 5 + cS, 4'b0100, 4'b0);

      // Mid-count reset on ch3; afterwards ch1 falls and ch2/ch3 rise together.
      run(4'b1100, 3, 0, 4'b0, 4'b0, 0, 4'b0, 4'b0);
      doReset(4'b1100, 1);
      run(4'b1100, 5 + cS + 3, 3 + cS, 4'b0, 4'b0010, 5 + cS, 4'b1100, 4'b0);

      stimDone = 1'b1;
      for (int k = 0; k < 10 && expQ.size() > 0; k++) @(posedge iCLK);
      #2;
      if (expQ.size() != 0) begin
         miscompares++;
         $display("FAIL drain: %0d expectations left unchecked, want 0", expQ.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
